// File: rtl/game_pkg.sv
// Shared game definitions: state codes used by game_ctrl, scene_display and
// the sprite layers, plus the saturating 4-digit BCD increment.
package game_pkg;

  localparam logic [1:0] GAME_INITIAL = 2'd0;
  localparam logic [1:0] GAME_PLAYING = 2'd1;
  localparam logic [1:0] GAME_OVER    = 2'd2;

  // Code 3 is never driven; it exists only so the FSM can recover from it.
  typedef enum logic [1:0] {
    ST_INITIAL = GAME_INITIAL,
    ST_PLAYING = GAME_PLAYING,
    ST_OVER    = GAME_OVER,
    ST_ILLEGAL = 2'd3
  } game_state_e;

  localparam logic [15:0] BCD4_MAX = 16'h9999;

  // Adds one to a 4-digit BCD value with per-digit carry; 9999 stays 9999.
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD4_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce sampled only on the game
// tick, and a one-clk press pulse on the debounced 0->1 edge.
module btn_debounce #(
  parameter int DEB_TICKS = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic tick_i,
  output logic press_o
);

  localparam int CW = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sample;

  assign sample = sync_q[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], btn_i};
  end

  // Count consecutive tick samples that disagree with the accepted level;
  // the level flips on the DEB_TICKS-th one, and a rising flip is a press.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    if (tick_i) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_TICKS - 1)) begin
        level_d = sample;
        cnt_d   = '0;
        press_o = sample;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register; released level after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: tick divider, debounced buttons, INITIAL/PLAYING/OVER FSM,
// BCD score with saturation and the high score captured on game over.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DEB_TICKS = 3,
  parameter int SCORE_DIV = 10,
  parameter int OVER_HOLD = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_jump,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic        clk_100Hz,
  output logic        tick_100Hz,
  output logic        jump_pulse,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int SW  = (SCORE_DIV < 2) ? 1 : $clog2(SCORE_DIV);
  localparam int HW  = $clog2(OVER_HOLD + 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          tick_q, clk100_q;

  game_state_e   state_q, state_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   hi_q, hi_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          start_press, jump_press;

  // Free-running divider count 0..DIV-1.
  always_comb begin
    cnt_d = (cnt_q == DW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
  end

  // Divider registers: tick is high in the clk after the count wraps, the
  // square wave is high while the count is in its lower half (one clk lag).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      clk100_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= (cnt_q == DW'(DIV - 1));
      clk100_q <= (cnt_q < DW'(DIV / 2));
    end
  end

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_start (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_start),
    .tick_i  (tick_q),
    .press_o (start_press)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_jump (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_jump),
    .tick_i  (tick_q),
    .press_o (jump_press)
  );

  // Next state, score, hold and high score; tick actions always use the
  // current (pre-transition) state, and a collision suppresses everything
  // else in PLAYING for that clk.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    hi_d       = hi_q;
    sub_d      = sub_q;
    hold_d     = hold_q;
    jump_pulse = 1'b0;
    case (state_q)
      ST_INITIAL: begin
        score_d = '0;
        sub_d   = '0;
        if (start_press || jump_press) state_d = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (collision) begin
          state_d = ST_OVER;
          hold_d  = '0;
          // Packed BCD compares correctly as an unsigned binary number.
          if (score_q > hi_q) hi_d = score_q;
        end else begin
          if (jump_press) jump_pulse = 1'b1;
          if (tick_q) begin
            if (sub_q == SW'(SCORE_DIV - 1)) begin
              sub_d   = '0;
              score_d = bcd4_inc(score_q);
            end else begin
              sub_d = sub_q + 1'b1;
            end
          end
        end
      end
      ST_OVER: begin
        if (tick_q && (hold_q != HW'(OVER_HOLD))) hold_d = hold_q + 1'b1;
        if (start_press && (hold_q == HW'(OVER_HOLD))) begin
          state_d = ST_INITIAL;
          score_d = '0;
        end
      end
      default: state_d = ST_INITIAL;
    endcase
  end

  // Game state, score and high score registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INITIAL;
      score_q <= '0;
      hi_q    <= '0;
      sub_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      sub_q   <= sub_d;
      hold_q  <= hold_d;
    end
  end

  assign game_state = state_q;
  assign clk_100Hz  = clk100_q;
  assign tick_100Hz = tick_q;
  assign score_bcd  = score_q;
  assign hi_bcd     = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed-plus-random bench for game_ctrl with DIV=10; expected values come
// from tick arithmetic (score = ticks/SCORE_DIV, hi = max of finished scores).
module tb_game_ctrl;
  import game_pkg::*;

  localparam int DIV       = 10;
  localparam int SCORE_DIV = 10;

  logic        clk = 1'b0;
  logic        rst, btn_start, btn_jump, collision;
  logic [1:0]  game_state;
  logic        clk_100Hz, tick_100Hz, jump_pulse;
  logic [15:0] score_bcd, hi_bcd;

  int checks = 0;
  int errors = 0;
  int play_ticks = 0;
  int over_ticks = 0;
  int jp_seen = 0;
  int jp_exp = 0;
  int hi_exp = 0;
  int n_play;
  logic [1:0] st_exp = GAME_INITIAL;

  always #5 clk = ~clk;

  game_ctrl #(
    .CLK_FREQ(1000), .TICK_HZ(100), .DEB_TICKS(3), .SCORE_DIV(10), .OVER_HOLD(100)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_jump(btn_jump),
    .collision(collision), .game_state(game_state), .clk_100Hz(clk_100Hz),
    .tick_100Hz(tick_100Hz), .jump_pulse(jump_pulse), .score_bcd(score_bcd),
    .hi_bcd(hi_bcd)
  );

  always @(negedge clk) if (jump_pulse === 1'b1) jp_seen++;

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the next tick clk, bounded to two tick periods.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick_100Hz !== 1'b1 && n < 2 * DIV);
    if (tick_100Hz !== 1'b1) check("tick_timeout", {31'd0, tick_100Hz}, 32'd1);
    if (st_exp == GAME_PLAYING) play_ticks++;
    if (st_exp == GAME_OVER)    over_ticks++;
  endtask

  // Collision raised for one non-tick clk somewhere after a tick.
  task automatic collide_off_tick();
    wait_tick();
    repeat ($urandom_range(1, 7)) @(negedge clk);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    st_exp = GAME_OVER;
    over_ticks = 0;
  endtask

  task automatic press_start_and_check(input string tag, input logic [1:0] st_after);
    btn_start = 1'b1;
    repeat (3) wait_tick();
    btn_start = 1'b0;
    @(negedge clk);
    check(tag, {30'd0, game_state}, {30'd0, st_after});
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b0; btn_jump = 1'b0; collision = 1'b0;

    // Reset state and divider waveform
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {30'd0, game_state}, {30'd0, GAME_INITIAL});
    check("rst_tick", {31'd0, tick_100Hz}, 32'd0);
    check("rst_clk100", {31'd0, clk_100Hz}, 32'd0);
    check("rst_jump", {31'd0, jump_pulse}, 32'd0);
    check("rst_score", {16'd0, score_bcd}, 32'd0);
    check("rst_hi", {16'd0, hi_bcd}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("div_tick", {31'd0, tick_100Hz}, {31'd0, (i % DIV) == 0});
      check("div_clk100", {31'd0, clk_100Hz}, {31'd0, ((i - 1) % DIV) < DIV / 2});
    end

    // Short jump glitch in INITIAL: no press, no start
    btn_jump = 1'b1;
    repeat ($urandom_range(1, 2)) wait_tick();
    btn_jump = 1'b0;
    repeat (4) wait_tick();
    check("glitch_state", {30'd0, game_state}, {30'd0, GAME_INITIAL});
    check("glitch_pulse", jp_seen, 0);

    // Start press accepted on the 3rd sampled tick, state follows one clk later
    btn_start = 1'b1;
    wait_tick();
    wait_tick();
    wait_tick();
    check("start_before", {30'd0, game_state}, {30'd0, GAME_INITIAL});
    @(negedge clk);
    check("start_after", {30'd0, game_state}, {30'd0, GAME_PLAYING});
    check("start_no_jump", jp_seen, 0);
    st_exp = GAME_PLAYING;
    play_ticks = 0;
    wait_tick();
    wait_tick();
    btn_start = 1'b0;

    // Random jump presses: exactly one pulse, on the 3rd held tick
    repeat ($urandom_range(2, 4)) begin
      int h;
      h = $urandom_range(3, 5);
      btn_jump = 1'b1;
      for (int i = 1; i <= h; i++) begin
        wait_tick();
        check("jump_pulse", {31'd0, jump_pulse}, {31'd0, i == 3});
      end
      btn_jump = 1'b0;
      jp_exp++;
      repeat (3) wait_tick();
      repeat ($urandom_range(0, 2)) wait_tick();
    end
    btn_jump = 1'b1;
    repeat ($urandom_range(1, 2)) wait_tick();
    btn_jump = 1'b0;
    repeat (3) wait_tick();
    check("jump_count", jp_seen, jp_exp);

    // Score after 120 ticks in PLAYING
    while (play_ticks < 120) wait_tick();
    @(negedge clk);
    check("score_120", {16'd0, score_bcd}, {16'd0, to_bcd(play_ticks / SCORE_DIV)});

    // BCD increment boundaries and random values against decimal arithmetic
    check("inc_0999", {16'd0, bcd4_inc(16'h0999)}, {16'd0, to_bcd(1000)});
    check("inc_9999", {16'd0, bcd4_inc(16'h9999)}, {16'd0, to_bcd(9999)});
    check("inc_0009", {16'd0, bcd4_inc(16'h0009)}, {16'd0, to_bcd(10)});
    for (int i = 0; i < 8; i++) begin
      int v;
      v = $urandom_range(0, 9999);
      check("inc_rand", {16'd0, bcd4_inc(to_bcd(v))}, {16'd0, to_bcd(v + 1)});
    end

    // Collision and jump press in the same tick clk
    btn_jump = 1'b1;
    wait_tick();
    wait_tick();
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 collision = 1'b1;
    @(negedge clk);
    check("coll_on_tick", {31'd0, tick_100Hz}, 32'd1);
    check("coll_no_jump", {31'd0, jump_pulse}, 32'd0);
    @(posedge clk);
    #1 collision = 1'b0;
    btn_jump = 1'b0;
    st_exp = GAME_OVER;
    over_ticks = 0;
    if (play_ticks / SCORE_DIV > hi_exp) hi_exp = play_ticks / SCORE_DIV;
    @(negedge clk);
    check("over1_state", {30'd0, game_state}, {30'd0, GAME_OVER});
    check("over1_score", {16'd0, score_bcd}, {16'd0, to_bcd(play_ticks / SCORE_DIV)});
    check("over1_hi", {16'd0, hi_bcd}, {16'd0, to_bcd(hi_exp)});
    check("over1_jumps", jp_seen, jp_exp);

    // OVER hold: press at hold 50 ignored, press after 100 ticks accepted
    while (over_ticks < 47) wait_tick();
    press_start_and_check("hold50_ignored", GAME_OVER);
    repeat (3) wait_tick();
    check("over_frozen", {16'd0, score_bcd}, {16'd0, to_bcd(play_ticks / SCORE_DIV)});
    while (over_ticks < 98) wait_tick();
    press_start_and_check("hold_accept", GAME_INITIAL);
    st_exp = GAME_INITIAL;
    check("restart_score", {16'd0, score_bcd}, 32'd0);
    check("restart_hi", {16'd0, hi_bcd}, {16'd0, to_bcd(hi_exp)});
    repeat (3) wait_tick();

    // Game 2: started by jump (no pulse), lower score keeps hi
    btn_jump = 1'b1;
    repeat (3) wait_tick();
    @(negedge clk);
    check("jump_start", {30'd0, game_state}, {30'd0, GAME_PLAYING});
    check("jump_start_nopulse", jp_seen, jp_exp);
    btn_jump = 1'b0;
    st_exp = GAME_PLAYING;
    play_ticks = 0;
    n_play = $urandom_range(20, 110);
    while (play_ticks < n_play) wait_tick();
    collide_off_tick();
    check("over2_state", {30'd0, game_state}, {30'd0, GAME_OVER});
    check("over2_score", {16'd0, score_bcd}, {16'd0, to_bcd(play_ticks / SCORE_DIV)});
    check("over2_hi", {16'd0, hi_bcd}, {16'd0, to_bcd(hi_exp)});
    while (over_ticks < 97) wait_tick();
    press_start_and_check("hold100_edge", GAME_OVER);
    repeat (3) wait_tick();
    press_start_and_check("hold_accept2", GAME_INITIAL);
    st_exp = GAME_INITIAL;
    repeat (3) wait_tick();

    // Game 3: higher score raises hi
    press_start_and_check("start3", GAME_PLAYING);
    st_exp = GAME_PLAYING;
    play_ticks = 0;
    n_play = $urandom_range(125, 180);
    while (play_ticks < n_play) wait_tick();
    collide_off_tick();
    if (play_ticks / SCORE_DIV > hi_exp) hi_exp = play_ticks / SCORE_DIV;
    check("over3_hi", {16'd0, hi_bcd}, {16'd0, to_bcd(hi_exp)});
    while (over_ticks < 100) wait_tick();
    press_start_and_check("exit3", GAME_INITIAL);
    st_exp = GAME_INITIAL;
    repeat (3) wait_tick();
    press_start_and_check("start4", GAME_PLAYING);
    st_exp = GAME_PLAYING;
    play_ticks = 0;
    while (play_ticks < 15) wait_tick();

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_state", {30'd0, game_state}, {30'd0, GAME_INITIAL});
    check("arst_score", {16'd0, score_bcd}, 32'd0);
    check("arst_hi", {16'd0, hi_bcd}, 32'd0);
    check("arst_tick", {31'd0, tick_100Hz}, 32'd0);
    check("arst_clk100", {31'd0, clk_100Hz}, 32'd0);
    check("arst_jump", {31'd0, jump_pulse}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    st_exp = GAME_INITIAL;
    repeat (5) @(negedge clk);
    check("post_rst_state", {30'd0, game_state}, {30'd0, GAME_INITIAL});
    check("post_rst_hi", {16'd0, hi_bcd}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
